// File: rtl/mmio_fifo_bank_pkg.sv
// mmio_fifo_bank_pkg
//   Shared address-map constants for the mmio_fifo_bank slice.
//   Address layout: addr[3:2] selects the region, addr[1:0] selects the channel.
package mmio_fifo_bank_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'b00,   // write: push, read: pop
        REG_COUNT  = 2'b01,   // read: channel occupancy
        REG_STATUS = 2'b10,   // read: {ovf, unf, full, empty}, clears ovf/unf
        REG_ZERO   = 2'b11    // reads as zero; 4'hF on the write side is flush
    } region_e;

    localparam logic [3:0] FLUSH_ADDR = 4'hF;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_UNF   = 2;
    localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/mmio_fifo_bank_chan_fifo.sv
// chan_fifo
//   One FIFO channel of the bank. Push and pop requests arrive already
//   decoded; this module decides which of them are accepted.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, pop    operation requests for this edge
//   flush        empty the channel (wins over push/pop state update)
//   din          push data
//   dout         current head entry
//   count        occupancy, 0..DEPTH
//   full, empty  occupancy flags
module chan_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];

    // A push into a full channel is still accepted when a pop frees a slot
    // at the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_fifo_bank.sv
// mmio_fifo_bank
//   Address-mapped bank of NCH independent FIFO channels behind a
//   write/read method port pair, with sticky read-to-clear overflow and
//   underflow flags and a global flush.
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   write_address   write target (00_c push, 1111 flush)
//   write_data      push data
//   write_en        write strobe, acted on when write_rdy=1
//   write_rdy       registered write ready
//   read_address    read target (00_c pop, 01_c count, 10_c status)
//   read_en         read strobe, acted on when read_rdy=1
//   read_data       combinational read result, zero when no read fires
//   read_rdy        registered read ready
module mmio_fifo_bank
    import mmio_fifo_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_fire;
    logic              rd_fire;
    logic              flush;
    region_e           wr_region;
    region_e           rd_region;
    logic [1:0]        wr_ch;
    logic [1:0]        rd_ch;

    logic [NCH-1:0]    push;
    logic [NCH-1:0]    pop;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    unf;
    logic [NCH-1:0]    ovf_set;
    logic [NCH-1:0]    unf_set;
    logic [NCH-1:0]    stat_clr;
    logic [DATA_W-1:0] dout  [NCH];
    logic [CNT_W-1:0]  count [NCH];

    assign wr_fire   = write_en & write_rdy;
    assign rd_fire   = read_en & read_rdy;
    assign wr_region = region_e'(write_address[3:2]);
    assign rd_region = region_e'(read_address[3:2]);
    assign wr_ch     = write_address[1:0];
    assign rd_ch     = read_address[1:0];
    assign flush     = wr_fire & (write_address == FLUSH_ADDR);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            write_rdy <= 1'b0;
            read_rdy  <= 1'b0;
        end else begin
            write_rdy <= 1'b1;
            read_rdy  <= 1'b1;
        end
    end

    // Channels at or beyond NCH have no instance, so their addresses decode
    // to nothing and their reads fall through to zero.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign push[g]     = wr_fire & (wr_region == REG_DATA) & (wr_ch == 2'(g));
        assign pop[g]      = rd_fire & (rd_region == REG_DATA) & (rd_ch == 2'(g));
        assign stat_clr[g] = rd_fire & (rd_region == REG_STATUS) & (rd_ch == 2'(g));
        // Full implies non-empty, so any pop on a full channel makes room.
        assign ovf_set[g]  = push[g] & full[g] & ~pop[g];
        assign unf_set[g]  = pop[g] & empty[g];

        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk   (CLK),
            .rst_n (RST_N),
            .push  (push[g]),
            .pop   (pop[g]),
            .flush (flush),
            .din   (write_data),
            .dout  (dout[g]),
            .count (count[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Set has priority over the read-to-clear of the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf <= '0;
            unf <= '0;
        end else begin
            ovf <= (ovf & ~stat_clr) | ovf_set;
            unf <= (unf & ~stat_clr) | unf_set;
        end
    end

    always_comb begin
        read_data = '0;
        if (rd_fire) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (rd_ch == 2'(c)) begin
                    case (rd_region)
                        REG_DATA: begin
                            if (!empty[c]) begin
                                read_data = dout[c];
                            end
                        end
                        REG_COUNT: begin
                            read_data[CNT_W-1:0] = count[c];
                        end
                        REG_STATUS: begin
                            read_data[ST_EMPTY] = empty[c];
                            read_data[ST_FULL]  = full[c];
                            read_data[ST_UNF]   = unf[c];
                            read_data[ST_OVF]   = ovf[c];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// tb_mmio_fifo_bank
//   Directed stimulus with literal expectations, plus a queue-based model
//   checked against read_data / write_rdy / read_rdy on every cycle.
module tb_mmio_fifo_bank;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NCH    = 2;
    localparam int unsigned ADDR_W = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [ADDR_W-1:0] write_address = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              write_en = 1'b0;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address = '0;
    logic              read_en = 1'b0;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mmio_fifo_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NCH    (NCH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] q [NCH][$];
    bit                m_rdy = 0;
    bit                m_ovf [NCH];
    bit                m_unf [NCH];

    function automatic logic [DATA_W-1:0] model_read();
        int ch;
        int rg;
        if (!(read_en && m_rdy)) return '0;
        rg = int'(read_address[3:2]);
        ch = int'(read_address[1:0]);
        if (ch >= int'(NCH)) return '0;
        case (rg)
            0: return (q[ch].size() > 0) ? q[ch][0] : '0;
            1: return DATA_W'(q[ch].size());
            2: return DATA_W'({m_ovf[ch], m_unf[ch],
                               q[ch].size() == int'(DEPTH), q[ch].size() == 0});
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        int rch;
        int wch;
        if (!RST_N) begin
            for (int c = 0; c < int'(NCH); c++) begin
                q[c].delete();
                m_ovf[c] = 0;
                m_unf[c] = 0;
            end
            m_rdy = 0;
            return;
        end
        if (read_en && m_rdy) begin
            rch = int'(read_address[1:0]);
            if (rch < int'(NCH)) begin
                if (read_address[3:2] == 2'b00) begin
                    if (q[rch].size() > 0) void'(q[rch].pop_front());
                    else m_unf[rch] = 1;
                end else if (read_address[3:2] == 2'b10) begin
                    m_ovf[rch] = 0;
                    m_unf[rch] = 0;
                end
            end
        end
        if (write_en && m_rdy) begin
            wch = int'(write_address[1:0]);
            if (write_address == 4'hF) begin
                for (int c = 0; c < int'(NCH); c++) q[c].delete();
            end else if (write_address[3:2] == 2'b00 && wch < int'(NCH)) begin
                if (q[wch].size() < int'(DEPTH)) q[wch].push_back(write_data);
                else m_ovf[wch] = 1;
            end
        end
        m_rdy = 1;
    endtask

    // Model advances at each rising edge; outputs are compared mid-cycle.
    initial begin
        logic [DATA_W-1:0] exp_rd;
        forever begin
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            exp_rd = model_read();
            n_cmp++;
            if (read_data !== exp_rd) begin
                n_err++;
                $display("FAIL model_read_data t=%0t addr=%h got=%h exp=%h",
                         $time, read_address, read_data, exp_rd);
            end
            n_cmp++;
            if (write_rdy !== m_rdy || read_rdy !== m_rdy) begin
                n_err++;
                $display("FAIL model_rdy t=%0t got=%b/%b exp=%b",
                         $time, write_rdy, read_rdy, m_rdy);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One cycle with optional write and read; inputs change #1 after the edge.
    task automatic op(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                      input bit re, input logic [3:0] ra,
                      input bit chk, input logic [7:0] exp, input string name);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
        @(negedge CLK);
        if (chk) check(name, read_data, exp);
        @(posedge CLK);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        op(1, a, d, 0, 4'h0, 0, 8'h00, "");
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        op(0, 4'h0, 8'h00, 1, a, 1, exp, name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for 3 edges with strobes asserted; they must be ignored.
        RST_N = 1'b0;
        write_en = 1'b1;
        read_en  = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_write_rdy", 8'(write_rdy), 8'h00);
        check("rst_read_rdy", 8'(read_rdy), 8'h00);
        check("rst_read_data", read_data, 8'h00);
        #4;
        RST_N = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        @(posedge CLK);
        #1;
        check("rdy_after_release", {6'b0, write_rdy, read_rdy}, 8'h03);
        rd(4'h4, 8'h00, "reset_count0");
        rd(4'h5, 8'h00, "reset_count1");
        rd(4'h8, 8'h01, "reset_status0");

        // Order and isolation
        wr(4'h0, 8'h11);
        wr(4'h0, 8'h22);
        wr(4'h0, 8'h33);
        wr(4'h1, 8'hAA);
        rd(4'h0, 8'h11, "order_pop0_a");
        rd(4'h0, 8'h22, "order_pop0_b");
        rd(4'h0, 8'h33, "order_pop0_c");
        rd(4'h1, 8'hAA, "order_pop1");
        rd(4'h4, 8'h00, "order_count0");

        // Overflow
        for (int i = 1; i <= 5; i++) wr(4'h0, 8'(i));
        rd(4'h4, 8'h04, "ovf_count");
        rd(4'h8, 8'h0A, "ovf_status");
        rd(4'h8, 8'h02, "ovf_status_cleared");
        for (int i = 1; i <= 4; i++) rd(4'h0, 8'(i), "ovf_pop");

        // Underflow with simultaneous push
        op(1, 4'h1, 8'h5A, 1, 4'h1, 1, 8'h00, "unf_pop_data");
        rd(4'h5, 8'h01, "unf_count1");
        rd(4'h9, 8'h04, "unf_status1");
        rd(4'h1, 8'h5A, "unf_pop_after");

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) wr(4'h0, 8'(8'h10 + i));
        op(1, 4'h0, 8'h14, 1, 4'h0, 1, 8'h10, "full_pushpop");
        rd(4'h8, 8'h02, "full_no_ovf");
        for (int i = 1; i <= 4; i++) rd(4'h0, 8'(8'h10 + i), "full_pop");
        rd(4'h8, 8'h01, "full_drained");

        // Wrap, then flush with a sticky set on ch1
        for (int i = 0; i < 6; i++) begin
            wr(4'h0, 8'(8'h40 + i));
            rd(4'h0, 8'(8'h40 + i), "wrap_pop");
        end
        wr(4'h0, 8'h60);
        wr(4'h0, 8'h61);
        rd(4'h1, 8'h00, "pre_flush_unf");
        wr(4'hF, 8'hFF);
        rd(4'h4, 8'h00, "flush_count0");
        rd(4'h5, 8'h00, "flush_count1");
        rd(4'h9, 8'h05, "flush_sticky1");
        wr(4'h0, 8'h77);
        rd(4'h0, 8'h77, "flush_fresh_pop");

        // Flush with a simultaneous pop returns the pre-flush head
        wr(4'h1, 8'h3C);
        op(1, 4'hF, 8'h00, 1, 4'h1, 1, 8'h3C, "flush_pop_head");
        rd(4'h5, 8'h00, "flush_pop_count");

        // Unmapped channels and region 11
        wr(4'h2, 8'h99);
        rd(4'h2, 8'h00, "nch_pop");
        rd(4'h6, 8'h00, "nch_count");
        rd(4'hA, 8'h00, "nch_status");
        rd(4'hC, 8'h00, "region3");

        // Reset mid-operation with pending strobes
        wr(4'h0, 8'h21);
        wr(4'h0, 8'h22);
        write_en = 1'b1;
        write_address = 4'h0;
        write_data = 8'h23;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        write_en = 1'b0;
        @(posedge CLK);
        #1;
        rd(4'h4, 8'h00, "midrst_count0");
        rd(4'h8, 8'h01, "midrst_status0");

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_fifo_bank.md
# mmio_fifo_bank

Parametrised, address-mapped bank of NCH independent FIFO channels, driven through the same write/read method-style port pair (address, data, enable, ready) as our existing single-bit register DUTs. Writes push into a channel selected by address, reads pop or inspect status. Overflow and underflow are flagged in sticky, read-to-clear bits, and a global flush is provided. It sits behind a cocotb test wrapper as the next-generation DUT for interface exercises.

## Interface
- DATA_W, 8: data width, ≥4.
- DEPTH, 4: entries per channel, power of two, ≥2; clog2(DEPTH)+1 ≤ DATA_W.
- NCH, 2: channel count, 1..4.
- ADDR_W, 4: address width, fixed at 4 for the map below.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset; synchronous and active-low.
- write_address  in  ADDR_W  write target.
- write_data  in  DATA_W  push data.
- write_en  in  1  write strobe; acted on only when write_rdy=1.
- write_rdy  out  1  write method ready.
- read_address  in  ADDR_W  read target.
- read_en  in  1  read strobe; acted on only when read_rdy=1.
- read_data  out  DATA_W  read result, combinational, same cycle as read_en.
- read_rdy  out  1  read method ready.

## Operation
- Address regions, addr[3:2]; channel c = addr[1:0].
- Write 00_c: push write_data into channel c.
- Write 1111: flush all channels (data ignored). Other write addresses ignored.
- Read 00_c: pop channel c; read_data = head entry.
- Read 01_c: read_data = count of channel c, zero-extended; no side effect.
- Read 10_c: read_data = {0…, ovf, unf, full, empty} in bits [3:0]; ovf and unf of channel c clear at the edge (read-to-clear).
- Read 11xx: read_data = 0.
- c ≥ NCH: reads return 0, writes are ignored, no flags.
- read_data = 0 whenever read_en=0 or read_rdy=0.
- Push to a full channel: data dropped, ovf set, count unchanged.
- Pop of an empty channel: read_data = 0, unf set, pointers unchanged.
- Flush: all counts and pointers to 0; sticky bits untouched.

## Timing
- Reset (RST_N=0 at an edge): all counts, pointers, ovf and unf = 0. write_rdy = read_rdy = 0. read_data = 0.
- write_rdy and read_rdy are registered. They go to 1 at the first edge with RST_N=1 and stay at 1 until the next reset.
- Push and pop take effect at the edge. Count, full and empty reflect the operation from the next cycle.
- Read value is the pre-edge state, so a pop returns the head present during the read_en cycle.
- Simultaneous push and pop, same channel, not full, not empty: both happen; count unchanged.
- Push to a full channel with a simultaneous pop: the push is accepted, no ovf, count stays DEPTH.
- Pop of an empty channel with a simultaneous push: unf set, returns 0, push lands (no bypass), count becomes 1.
- Flush with a simultaneous pop: the pop returns the pre-flush head; the flush wins the state update.
- Flush with a simultaneous push (same edge): flush wins and the pushed data is discarded.
- Status read while a flag is being set in the same cycle: returns the old value. Set wins over clear, so the flag is 1 afterwards.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Reset mid-operation discards all contents, regardless of pending enables.

## Structure
- Package mmio_fifo_bank_pkg:
  - region codes REG_DATA=2'b00, REG_COUNT=2'b01, REG_STATUS=2'b10
  - FLUSH_ADDR=4'hF
  - status bit indices ST_EMPTY=0, ST_FULL=1, ST_UNF=2, ST_OVF=3
- Sub-module chan_fifo: one channel.
  - Parameters DATA_W, DEPTH.
  - Inputs push, pop, flush, din.
  - Outputs dout (head), count, full, empty.
  - It owns its pointers and the full-plus-pop acceptance rule.
- Top level handles address decode, the sticky flags, the ready registers and the read mux, with NCH instances of chan_fifo in a generate loop.

## Test plan
- Reset and rdy: hold RST_N=0 for 3 cycles, then release. Rdy is 0 during reset and 1 after the first edge with RST_N=1. Count reads (0x4, 0x5) return 0 and status 0x8 returns 0x1.
- Order and isolation: push 0x11, 0x22, 0x33 to ch0 and 0xAA to ch1. Pops on 0x0 return 0x11, 0x22, 0x33; 0x1 returns 0xAA. Read 0x4 then returns 0.
- Overflow: push 5 values 0x01..0x05 to ch0. Read 0x4 = 4 and 0x8 = 0xA (ovf, full); a second 0x8 read = 0x2. Pops return 0x01..0x04.
- Underflow plus simultaneous push: with ch1 empty, pop 0x1 while pushing 0x5A to ch1 in the same cycle. read_data = 0x00. Then 0x5 = 1, 0x9 = 0x4 (unf); a following pop returns 0x5A.
- Full with simultaneous push and pop: fill ch0 with 0x10..0x13, then in one cycle pop and push 0x14. Pop returns 0x10, no ovf. Subsequent pops return 0x11..0x14.
- Flush and wrap: push 6 and pop 6 alternately to wrap the ch0 pointers, push 2 more, write 0xF. Counts read 0 while stickies are unchanged. A fresh push of 0x77 then pops 0x77.
